// File: rtl/time_set_editor_pkg.sv
// Shared definitions for the watch time editor: FSM states, cursor
// positions and the per-digit maxima used by the increment logic.
package time_set_editor_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EDIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [1:0] CUR_H1 = 2'd3;
  localparam logic [1:0] CUR_H0 = 2'd2;
  localparam logic [1:0] CUR_M1 = 2'd1;
  localparam logic [1:0] CUR_M0 = 2'd0;

  localparam logic [3:0] MAX_H1    = 4'd2;
  localparam logic [3:0] MAX_H0_20 = 4'd3;  // hour0 limit while hour1 == 2
  localparam logic [3:0] MAX_H0    = 4'd9;
  localparam logic [3:0] MAX_M1    = 4'd5;
  localparam logic [3:0] MAX_M0    = 4'd9;

  // Increment a BCD digit, wrapping to 0 once it reaches (or exceeds) its max.
  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] max_val);
    return (d >= max_val) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/time_set_editor_button_debounce.sv
// Raw button conditioning: two-flop synchroniser, level debounce that needs
// DEB_CYCLES consecutive differing samples before accepting a new level, and
// a rising-edge detector producing a single-cycle pulse per accepted press.
module time_set_editor_button_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Down-count differing samples; any sample matching the accepted level rearms the timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= CNT_LOAD;
    end else if (cnt == '0) begin
      level <= sync2;
      cnt   <= CNT_LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Remember the previous accepted level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/time_set_editor.sv
// Watch time editor: captures the running time on entering edit mode, lets
// the user step a cursor across HH:MM and bump the digit under it within its
// legal range, blinks the selected digit, and pulses load on leaving edit.
//
//   state  | meaning
//   IDLE   | not editing, St_* hold last edited value
//   LOAD   | copy running time into St_*, cursor to hour1
//   EDIT   | buttons move cursor / increment digits, blink runs
//   COMMIT | one-cycle load pulse, watch adopts St_*
module time_set_editor
  import time_set_editor_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int BLINK_DIV  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       setValue,
  input  logic       nextd,
  input  logic       upTime,
  input  logic       resetTime,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [3:0] St_hour1,
  output logic [3:0] St_hour0,
  output logic [3:0] St_min1,
  output logic [3:0] St_min0,
  output logic [1:0] cursor,
  output logic       blink,
  output logic       editing,
  output logic       load
);

  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_DIV - 1);

  state_t        state_q;
  state_t        state_d;
  logic          up_pulse;
  logic          next_pulse;
  logic          edit_act;
  logic          do_clear;
  logic          do_up;
  logic          do_next;
  logic [3:0]    h1_n;
  logic [3:0]    h0_n;
  logic [3:0]    m1_n;
  logic [3:0]    m0_n;
  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  time_set_editor_button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (nextd),
    .pulse   (next_pulse)
  );

  time_set_editor_button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (upTime),
    .pulse   (up_pulse)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (setValue) state_d = S_LOAD;
      S_LOAD:   state_d = S_EDIT;
      S_EDIT:   if (!setValue) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign editing  = (state_q == S_EDIT);
  assign load     = (state_q == S_COMMIT);
  // Button activity only counts while staying in EDIT; resetTime overrides both buttons.
  assign edit_act = editing && setValue;
  assign do_clear = edit_act && resetTime;
  assign do_up    = edit_act && !resetTime && up_pulse;
  assign do_next  = edit_act && !resetTime && next_pulse;

  // Incremented digit set for the current cursor, including the hour0 clamp.
  always_comb begin
    h1_n = St_hour1;
    h0_n = St_hour0;
    m1_n = St_min1;
    m0_n = St_min0;
    case (cursor)
      CUR_H1: begin
        h1_n = wrap_inc(St_hour1, MAX_H1);
        if (h1_n == MAX_H1 && St_hour0 > MAX_H0_20) h0_n = MAX_H0_20;
      end
      CUR_H0:  h0_n = wrap_inc(St_hour0, (St_hour1 == MAX_H1) ? MAX_H0_20 : MAX_H0);
      CUR_M1:  m1_n = wrap_inc(St_min1, MAX_M1);
      CUR_M0:  m0_n = wrap_inc(St_min0, MAX_M0);
      default: ;
    endcase
  end

  // Digit and cursor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      St_hour1 <= '0;
      St_hour0 <= '0;
      St_min1  <= '0;
      St_min0  <= '0;
      cursor   <= CUR_H1;
    end else if (state_q == S_LOAD) begin
      St_hour1 <= cur_h1;
      St_hour0 <= cur_h0;
      St_min1  <= cur_m1;
      St_min0  <= cur_m0;
      cursor   <= CUR_H1;
    end else if (do_clear) begin
      St_hour1 <= '0;
      St_hour0 <= '0;
      St_min1  <= '0;
      St_min0  <= '0;
      cursor   <= CUR_H1;
    end else begin
      if (do_up) begin
        St_hour1 <= h1_n;
        St_hour0 <= h0_n;
        St_min1  <= m1_n;
        St_min0  <= m0_n;
      end
      // Cursor moves after the increment has used the old position; 0 wraps to 3.
      if (do_next) cursor <= cursor - 2'd1;
    end
  end

  // Blink half-period timer; restarts on any button pulse so the edited digit stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (!editing) begin
      blink_cnt <= BLINK_LOAD;
      blink_q   <= 1'b0;
    end else if (up_pulse || next_pulse) begin
      blink_cnt <= BLINK_LOAD;
      blink_q   <= 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt <= BLINK_LOAD;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

  assign blink = blink_q & editing;

endmodule

// File: tb/tb_time_set_editor.sv
module tb_time_set_editor;

  localparam int DEB = 4;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       setValue, nextd, upTime, resetTime;
  logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
  logic [3:0] St_hour1, St_hour0, St_min1, St_min0;
  logic [1:0] cursor;
  logic       blink, editing, load;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: plain integers for the four digits and the cursor
  int m_h1, m_h0, m_m1, m_m0, m_cur;

  time_set_editor #(.DEB_CYCLES(DEB), .BLINK_DIV(BLK)) dut (
    .clk(clk), .reset(reset), .setValue(setValue), .nextd(nextd), .upTime(upTime),
    .resetTime(resetTime), .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .St_hour1(St_hour1), .St_hour0(St_hour0), .St_min1(St_min1), .St_min0(St_min0),
    .cursor(cursor), .blink(blink), .editing(editing), .load(load)
  );

  always #5 clk = ~clk;

  wire [15:0] st_word = {St_hour1, St_hour0, St_min1, St_min0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_word();
    return {4'(m_h1), 4'(m_h0), 4'(m_m1), 4'(m_m0)};
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_st"}, 32'(st_word), 32'(model_word()));
    check({tag, "_cur"}, 32'(cursor), 32'(m_cur));
  endtask

  task automatic model_inc();
    case (m_cur)
      3: begin
        m_h1 = (m_h1 + 1) % 3;
        if (m_h1 == 2 && m_h0 > 3) m_h0 = 3;
      end
      2: m_h0 = (m_h0 + 1) % ((m_h1 == 2) ? 4 : 10);
      1: m_m1 = (m_m1 + 1) % 6;
      default: m_m0 = (m_m0 + 1) % 10;
    endcase
  endtask

  task automatic model_zero();
    m_h1 = 0; m_h0 = 0; m_m1 = 0; m_m0 = 0; m_cur = 3;
  endtask

  // Clean press of given length followed by a long enough release to settle.
  task automatic press(input bit is_up, input int len);
    if (is_up) upTime = 1'b1; else nextd = 1'b1;
    repeat (len) tick();
    upTime = 1'b0;
    nextd  = 1'b0;
    repeat (10) tick();
    if (len >= DEB) begin
      if (is_up) model_inc();
      else m_cur = (m_cur + 3) % 4;
    end
  endtask

  task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
    cur_h1 = 4'(h1); cur_h0 = 4'(h0); cur_m1 = 4'(m1); cur_m0 = 4'(m0);
  endtask

  task automatic enter_edit(input string tag);
    setValue = 1'b1;
    tick();
    check({tag, "_edit_lat1"}, 32'(editing), 32'd0);
    tick();
    check({tag, "_edit_lat2"}, 32'(editing), 32'd1);
    m_h1 = int'(cur_h1); m_h0 = int'(cur_h0); m_m1 = int'(cur_m1); m_m0 = int'(cur_m0);
    m_cur = 3;
    check_model({tag, "_loaded"});
  endtask

  task automatic exit_edit(input string tag);
    setValue = 1'b0;
    tick();
    check({tag, "_load_hi"}, 32'(load), 32'd1);
    check({tag, "_load_st"}, 32'(st_word), 32'(model_word()));
    check({tag, "_commit_blink"}, 32'(blink), 32'd0);
    tick();
    check({tag, "_load_lo"}, 32'(load), 32'd0);
    check({tag, "_idle"}, 32'(editing), 32'd0);
  endtask

  initial begin
    reset = 1'b1; setValue = 1'b0; nextd = 1'b0; upTime = 1'b0; resetTime = 1'b0;
    set_cur(0, 0, 0, 0);
    repeat (2) tick();
    check("rst_st", 32'(st_word), 32'h0000);
    check("rst_cursor", 32'(cursor), 32'd3);
    check("rst_editing", 32'(editing), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_load", 32'(load), 32'd0);

    // load 12:45, exercise blink timing and pulse-driven blink restart
    set_cur(1, 2, 4, 5);
    enter_edit("e1");
    check("e1_st_const", 32'(st_word), 32'h1245);
    repeat (BLK - 1) tick();
    check("blink_pre", 32'(blink), 32'd0);
    tick();
    check("blink_on", 32'(blink), 32'd1);
    nextd = 1'b1;
    repeat (6) tick();
    nextd = 1'b0;
    tick();
    m_cur = 2;
    check("blink_next_cur", 32'(cursor), 32'(m_cur));
    check("blink_cleared", 32'(blink), 32'd0);
    repeat (BLK - 1) tick();
    check("blink_restart_pre", 32'(blink), 32'd0);
    tick();
    check("blink_restart_on", 32'(blink), 32'd1);
    repeat (6) tick();
    exit_edit("e1");
    check("e1_commit_const", 32'(st_word), 32'h1245);

    // 19:00: hour1 increment clamps hour0 to 3, then wraps hour1
    set_cur(1, 9, 0, 0);
    enter_edit("e2");
    press(1'b1, 8);
    check_model("clamp");
    check("clamp_const", 32'(st_word), 32'h2300);
    press(1'b1, 8);
    check_model("wrap_h1");
    check("wrap_h1_const", 32'(st_word), 32'h0300);
    press(1'b0, 5);
    press(1'b0, 5);
    check("cursor_m1", 32'(cursor), 32'd1);
    for (int i = 0; i < 5; i++) press(1'b1, 5);
    check("m1_at_5", 32'(st_word), 32'h0350);
    press(1'b1, 5);
    check_model("m1_wrap");
    check("m1_wrap_const", 32'(St_min1), 32'd0);
    press(1'b0, 5); check("nav0", 32'(cursor), 32'd0);
    press(1'b0, 5); check("nav3", 32'(cursor), 32'd3);
    press(1'b0, 5); check("nav2", 32'(cursor), 32'd2);
    press(1'b0, 5); check("nav1", 32'(cursor), 32'd1);
    m_cur = 1;
    press(1'b1, 2);
    check_model("glitch");
    // latency: raw rise -> digit update after 2+DEB+1 edges, single pulse for a long hold
    upTime = 1'b1;
    repeat (2 + DEB) tick();
    upTime = 1'b0;
    check("lat_before", 32'(St_min1), 32'd0);
    tick();
    check("lat_after", 32'(St_min1), 32'd1);
    m_m1 = 1;
    repeat (10) tick();
    check_model("single_pulse");
    exit_edit("e2");

    // 21:37: resetTime wins over a coincident up pulse
    set_cur(2, 1, 3, 7);
    enter_edit("e3");
    check("e3_const", 32'(st_word), 32'h2137);
    upTime = 1'b1;
    repeat (2 + DEB) tick();
    resetTime = 1'b1;
    tick();
    resetTime = 1'b0;
    upTime = 1'b0;
    model_zero();
    check("rt_st", 32'(st_word), 32'h0000);
    check("rt_cursor", 32'(cursor), 32'd3);
    repeat (10) tick();
    check_model("rt_settle");

    // randomized editing against the reference model
    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k == 0) begin
        resetTime = 1'b1;
        tick();
        resetTime = 1'b0;
        tick();
        model_zero();
      end else begin
        press(k < 6, int'($urandom_range(1, 8)));
      end
      check_model("rand");
    end

    // reset in the middle of an edit aborts without a load pulse
    press(1'b1, 5);
    reset = 1'b1;
    setValue = 1'b0;
    repeat (2) tick();
    check("abort_st", 32'(st_word), 32'h0000);
    check("abort_editing", 32'(editing), 32'd0);
    check("abort_load", 32'(load), 32'd0);
    check("abort_cursor", 32'(cursor), 32'd3);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_load", 32'(load), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
